// File: rtl/rsc_enc_core.sv
// Duobinary 8-state circular RSC encoder: buffers a block, encodes from 0 to find the final state, then re-encodes from Sc.
// Output starts 3 enabled cycles after ieop; ordy drops for CIRC/ENC, so one block is in flight at a time.
module rsc_enc_core #(
  parameter int pN_MAX = 1024
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       iclkena,
  input  logic       isop,
  input  logic       ieop,
  input  logic       ival,
  input  logic [1:0] idat,
  output logic       ordy,
  output logic       osop,
  output logic       oeop,
  output logic       oval,
  output logic [1:0] odat,
  output logic       oy,
  output logic       ow,
  output logic       oerr
);

  localparam int CW = $clog2(pN_MAX + 1);
  localparam int AW = (pN_MAX > 1) ? $clog2(pN_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CIRC, S_ENC} state_t;

  // state vector s = {s1, s2, s3}; ab = {A, B}
  function automatic logic [2:0] trellis_next(input logic [2:0] s, input logic [1:0] ab);
    logic fb;
    fb = ab[1] ^ ab[0] ^ s[2] ^ s[0];
    return {fb, s[2] ^ ab[0], s[1] ^ ab[0]};
  endfunction

  function automatic logic [1:0] trellis_par(input logic [2:0] s, input logic [1:0] ab);
    logic fb;
    fb = ab[1] ^ ab[0] ^ s[2] ^ s[0];
    return {fb ^ s[1] ^ s[0], fb ^ s[0]};
  endfunction

  function automatic logic [2:0] gz_pow(input logic [2:0] s, input int p);
    logic [2:0] r;
    r = s;
    for (int i = 0; i < p; i++) r = {r[2] ^ r[0], r[2], r[1]};
    return r;
  endfunction

  function automatic logic [2:0] circ_search(input int p, input logic [2:0] sn);
    logic [2:0] r;
    logic [2:0] k3;
    r = 3'd0;
    if (p != 0) begin
      for (int k = 0; k < 8; k++) begin
        k3 = 3'(k);
        if ((gz_pow(k3, p) ^ k3) == sn) r = k3;
      end
    end
    return r;
  endfunction

  logic [2:0] circ_rom [0:6][0:7];

  for (genvar gp = 0; gp < 7; gp++) begin : g_rom_p
    for (genvar gs = 0; gs < 8; gs++) begin : g_rom_s
      assign circ_rom[gp][gs] = circ_search(gp, 3'(gs));
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ocnt;
  logic [2:0]    st;
  logic [2:0]    enc_st;
  logic [2:0]    mod7;
  logic          blk_err;
  logic [AW-1:0] rptr;
  logic [1:0]    rd_dat;
  logic [1:0]    mem [0:pN_MAX-1];

  logic          in_beat;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [2:0]    base_st;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    mod7_nxt;
  logic          full;
  logic          last_in;
  logic          last_out;

  always_comb begin
    in_beat  = ival && ((state == S_IDLE && isop) || state == S_LOAD);
    wr_addr  = isop ? '0 : cnt[AW-1:0];
    base_st  = isop ? 3'd0 : st;
    cnt_nxt  = isop ? CW'(1) : cnt + CW'(1);
    mod7_nxt = isop ? 3'd1 : ((mod7 == 3'd6) ? 3'd0 : mod7 + 3'd1);
    full     = (cnt_nxt == CW'(pN_MAX));
    last_in  = ieop || full;
    rd_addr  = (state == S_CIRC) ? '0 : rptr;
    last_out = (ocnt == cnt - CW'(1));
  end

  // block buffer: registered read feeds the encoder one cycle later
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (in_beat) mem[wr_addr] <= idat;
      rd_dat <= mem[rd_addr];
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state   <= S_IDLE;
      ordy    <= 1'b1;
      osop    <= 1'b0;
      oeop    <= 1'b0;
      oval    <= 1'b0;
      oerr    <= 1'b0;
      odat    <= 2'd0;
      oy      <= 1'b0;
      ow      <= 1'b0;
      cnt     <= '0;
      ocnt    <= '0;
      st      <= 3'd0;
      enc_st  <= 3'd0;
      mod7    <= 3'd0;
      blk_err <= 1'b0;
      rptr    <= '0;
    end else if (iclkena) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_beat) begin
            st      <= trellis_next(base_st, idat);
            cnt     <= cnt_nxt;
            mod7    <= mod7_nxt;
            // running past pN_MAX without ieop closes the block and flags it
            blk_err <= (isop ? 1'b0 : blk_err) | (full && !ieop);
            if (last_in) begin
              state <= S_CIRC;
              ordy  <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_CIRC: begin
          enc_st  <= circ_rom[mod7][st];
          blk_err <= blk_err | (mod7 == 3'd0) | (cnt < CW'(2));
          rptr    <= AW'(1);
          ocnt    <= '0;
          state   <= S_ENC;
        end
        S_ENC: begin
          oval      <= 1'b1;
          osop      <= (ocnt == '0);
          oeop      <= last_out;
          odat      <= rd_dat;
          {oy, ow}  <= trellis_par(enc_st, rd_dat);
          enc_st    <= trellis_next(enc_st, rd_dat);
          oerr      <= last_out ? blk_err : ((ocnt == '0) ? 1'b0 : oerr);
          ocnt      <= ocnt + CW'(1);
          rptr      <= rptr + AW'(1);
          if (last_out) begin
            state <= S_IDLE;
            ordy  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ordy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
